// File: rtl/psr_window_unit.sv
// Processor status block: registered icc flags, current window pointer with SAVE/RESTORE
// wrap-around, window invalid mask, overflow/underflow trap pulse and Bicc evaluation.
module psr_window_unit #(
   parameter int unsigned NWINDOWS = 8,
   localparam int unsigned CWP_W = (NWINDOWS > 2) ? $clog2(NWINDOWS) : 1
) (
   input  logic                Clk,
   input  logic                Clr,
   input  logic                Z,
   input  logic                N,
   input  logic                C,
   input  logic                V,
   input  logic                LE,
   input  logic                Save,
   input  logic                Restore,
   input  logic                WIM_LE,
   input  logic [NWINDOWS-1:0] WIM_In,
   input  logic [3:0]          Cond,
   output logic [3:0]          PSR_Out,
   output logic                bit_C,
   output logic [CWP_W-1:0]    CWP,
   output logic [NWINDOWS-1:0] WIM,
   output logic                Cond_True,
   output logic                Trap,
   output logic [1:0]          Trap_Type
);

   localparam logic [CWP_W-1:0] CwpMax = CWP_W'(NWINDOWS - 1);
   localparam logic [CWP_W-1:0] CwpOne = CWP_W'(1);

   logic [3:0]          icc_q, icc_d;
   logic [CWP_W-1:0]    cwp_q, cwp_d;
   logic [NWINDOWS-1:0] wim_q, wim_d;
   logic                trap_q, trap_d;
   logic [1:0]          trap_type_q, trap_type_d;
   logic [CWP_W-1:0]    save_tgt, restore_tgt;

   // Explicit wrap keeps CWP inside 0..NWINDOWS-1 for non-power-of-two window counts.
   always_comb begin
      save_tgt    = (cwp_q == '0) ? CwpMax : cwp_q - CwpOne;
      restore_tgt = (cwp_q == CwpMax) ? '0 : cwp_q + CwpOne;
   end

   always_comb begin
      icc_d       = icc_q;
      cwp_d       = cwp_q;
      wim_d       = wim_q;
      trap_d      = 1'b0;
      trap_type_d = 2'b00;
      if (LE) begin
         icc_d = {Z, N, C, V};
      end
      if (WIM_LE) begin
         wim_d = WIM_In;
      end
      // Window checks use the WIM held before this edge; Save+Restore together is a NOP.
      if (Save && !Restore) begin
         if (wim_q[save_tgt]) begin
            trap_d      = 1'b1;
            trap_type_d = 2'b01;
         end else begin
            cwp_d = save_tgt;
         end
      end else if (Restore && !Save) begin
         if (wim_q[restore_tgt]) begin
            trap_d      = 1'b1;
            trap_type_d = 2'b10;
         end else begin
            cwp_d = restore_tgt;
         end
      end
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         icc_q       <= '0;
         cwp_q       <= '0;
         wim_q       <= '0;
         trap_q      <= 1'b0;
         trap_type_q <= 2'b00;
      end else begin
         icc_q       <= icc_d;
         cwp_q       <= cwp_d;
         wim_q       <= wim_d;
         trap_q      <= trap_d;
         trap_type_q <= trap_type_d;
      end
   end

   // Bicc decode on the registered flags {Z,N,C,V}.
   always_comb begin
      Cond_True = 1'b0;
      unique case (Cond)
         4'h0: Cond_True = 1'b0;
         4'h1: Cond_True = icc_q[3];
         4'h2: Cond_True = icc_q[3] | (icc_q[2] ^ icc_q[0]);
         4'h3: Cond_True = icc_q[2] ^ icc_q[0];
         4'h4: Cond_True = icc_q[1] | icc_q[3];
         4'h5: Cond_True = icc_q[1];
         4'h6: Cond_True = icc_q[2];
         4'h7: Cond_True = icc_q[0];
         4'h8: Cond_True = 1'b1;
         4'h9: Cond_True = ~icc_q[3];
         4'hA: Cond_True = ~(icc_q[3] | (icc_q[2] ^ icc_q[0]));
         4'hB: Cond_True = ~(icc_q[2] ^ icc_q[0]);
         4'hC: Cond_True = ~(icc_q[1] | icc_q[3]);
         4'hD: Cond_True = ~icc_q[1];
         4'hE: Cond_True = ~icc_q[2];
         4'hF: Cond_True = ~icc_q[0];
         default: Cond_True = 1'b0;
      endcase
   end

   assign PSR_Out   = icc_q;
   assign bit_C     = icc_q[1];
   assign CWP       = cwp_q;
   assign WIM       = wim_q;
   assign Trap      = trap_q;
   assign Trap_Type = trap_type_q;

endmodule

// File: tb/tb_psr_window_unit.sv
// Scoreboard bench for psr_window_unit: an 8-window instance carries most traffic, a
// 5-window instance checks non-power-of-two wrap.
module tb_psr_window_unit;

   typedef struct {
      logic [3:0] psr;
      logic [2:0] cwp;
      logic [7:0] wim;
      logic       trap;
      logic [1:0] tt;
      logic [2:0] cwp5;
   } exp_t;

   logic       clk = 1'b0;
   logic       clr;
   logic       z = 0, n = 0, c = 0, v = 0, le = 0, save = 0, restore = 0, wim_le = 0;
   logic [7:0] wim_in = '0;
   logic [3:0] cond = '0;
   logic       save5 = 0, restore5 = 0, wim_le5 = 0;
   logic [4:0] wim_in5 = '0;

   logic [3:0] psr_out, psr_out5;
   logic       bit_c, bit_c5, cond_true, cond_true5, trap, trap5;
   logic [2:0] cwp, cwp5;
   logic [7:0] wim;
   logic [4:0] wim5;
   logic [1:0] trap_type, trap_type5;

   int checks = 0;
   int failures = 0;
   exp_t sb[$];

   logic [3:0] m_psr;
   logic [7:0] m_wim;
   int         m_cwp, m_cwp5;

   always #5 clk = ~clk;

   psr_window_unit #(.NWINDOWS(8)) u_dut8 (
      .Clk(clk), .Clr(clr), .Z(z), .N(n), .C(c), .V(v), .LE(le), .Save(save),
      .Restore(restore), .WIM_LE(wim_le), .WIM_In(wim_in), .Cond(cond),
      .PSR_Out(psr_out), .bit_C(bit_c), .CWP(cwp), .WIM(wim), .Cond_True(cond_true),
      .Trap(trap), .Trap_Type(trap_type)
   );

   psr_window_unit #(.NWINDOWS(5)) u_dut5 (
      .Clk(clk), .Clr(clr), .Z(z), .N(n), .C(c), .V(v), .LE(le), .Save(save5),
      .Restore(restore5), .WIM_LE(wim_le5), .WIM_In(wim_in5), .Cond(cond),
      .PSR_Out(psr_out5), .bit_C(bit_c5), .CWP(cwp5), .WIM(wim5), .Cond_True(cond_true5),
      .Trap(trap5), .Trap_Type(trap_type5)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic bicc(input logic [3:0] cd, input logic [3:0] f);
      logic b;
      case (cd[2:0])
         3'd0: b = 1'b0;
         3'd1: b = f[3];
         3'd2: b = f[3] | (f[2] ^ f[0]);
         3'd3: b = f[2] ^ f[0];
         3'd4: b = f[1] | f[3];
         3'd5: b = f[1];
         3'd6: b = f[2];
         default: b = f[0];
      endcase
      return b ^ cd[3];
   endfunction

   task automatic model_reset();
      m_psr = '0; m_wim = '0; m_cwp = 0; m_cwp5 = 0;
   endtask

   // One clock of stimulus: predict, push, clock, pop and compare, then idle the strobes.
   task automatic cyc(input logic [3:0] f, input logic l, input logic sv, input logic rs,
                      input logic wl, input logic [7:0] wv,
                      input logic sv5 = 1'b0, input logic rs5 = 1'b0);
      exp_t e;
      exp_t g;
      int   t;
      {z, n, c, v} = f; le = l; save = sv; restore = rs; wim_le = wl; wim_in = wv;
      save5 = sv5; restore5 = rs5;
      e.trap = 1'b0; e.tt = 2'b00;
      if (l) m_psr = f;
      if (sv && !rs) begin
         t = (m_cwp + 7) % 8;
         if (m_wim[t]) begin e.trap = 1'b1; e.tt = 2'b01; end
         else m_cwp = t;
      end else if (rs && !sv) begin
         t = (m_cwp + 1) % 8;
         if (m_wim[t]) begin e.trap = 1'b1; e.tt = 2'b10; end
         else m_cwp = t;
      end
      if (sv5 && !rs5) m_cwp5 = (m_cwp5 + 4) % 5;
      else if (rs5 && !sv5) m_cwp5 = (m_cwp5 + 1) % 5;
      if (wl) m_wim = wv;
      e.psr = m_psr; e.cwp = 3'(m_cwp); e.wim = m_wim; e.cwp5 = 3'(m_cwp5);
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      check("psr_out", 32'(psr_out), 32'(g.psr));
      check("bit_c", 32'(bit_c), 32'(g.psr[1]));
      check("cwp", 32'(cwp), 32'(g.cwp));
      check("wim", 32'(wim), 32'(g.wim));
      check("trap", 32'(trap), 32'(g.trap));
      check("trap_type", 32'(trap_type), 32'(g.tt));
      check("cwp5", 32'(cwp5), 32'(g.cwp5));
      le = 0; save = 0; restore = 0; wim_le = 0; save5 = 0; restore5 = 0;
   endtask

   initial begin
      clr = 1'b1;
      #1 clr = 1'b0;
      {z, n, c, v} = 4'b1111; le = 1'b1; save = 1'b1; wim_le = 1'b1; wim_in = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      check("rst_psr", 32'(psr_out), 0);
      check("rst_bit_c", 32'(bit_c), 0);
      check("rst_cwp", 32'(cwp), 0);
      check("rst_wim", 32'(wim), 0);
      check("rst_trap", 32'(trap), 0);
      check("rst_trap_type", 32'(trap_type), 0);
      check("rst_cwp5", 32'(cwp5), 0);
      le = 0; save = 0; wim_le = 0; wim_in = '0;
      @(negedge clk) clr = 1'b1;
      model_reset();

      // icc load then hold
      cyc(4'b1011, 1, 0, 0, 0, 8'h00);
      cyc(4'b0100, 0, 0, 0, 0, 8'h00);
      // SAVE wrap 0 -> 7, RESTORE wrap 7 -> 0; 5-window instance wraps 0 -> 4 -> 3 -> 4 -> 0
      cyc(4'b0000, 0, 1, 0, 0, 8'h00, 1, 0);
      cyc(4'b0000, 0, 0, 1, 0, 8'h00, 1, 0);
      cyc(4'b0000, 0, 0, 0, 0, 8'h00, 0, 1);
      cyc(4'b0000, 0, 0, 0, 0, 8'h00, 0, 1);
      // overflow trap, then pulse ends
      cyc(4'b0000, 0, 0, 0, 1, 8'h80);
      cyc(4'b0000, 0, 1, 0, 0, 8'h00);
      cyc(4'b0000, 0, 0, 0, 0, 8'h00);
      // underflow trap, back-to-back
      cyc(4'b0000, 0, 0, 0, 1, 8'h02);
      cyc(4'b0000, 0, 0, 1, 0, 8'h00);
      cyc(4'b0000, 0, 0, 1, 0, 8'h00);
      cyc(4'b0000, 0, 0, 0, 0, 8'h00);
      // collisions: Save+Restore NOP; Save against old WIM with icc load alongside
      cyc(4'b0000, 0, 0, 0, 1, 8'h00);
      cyc(4'b0000, 0, 1, 1, 0, 8'h00);
      cyc(4'b0110, 1, 1, 0, 1, 8'h80);
      cyc(4'b0000, 0, 0, 1, 0, 8'h00);
      cyc(4'b0000, 0, 1, 0, 0, 8'h00);

      // Bicc sweep over all flag combinations
      for (int f = 0; f < 16; f++) begin
         cyc(4'(f), 1, 0, 0, 0, 8'h00);
         for (int cd = 0; cd < 16; cd++) begin
            cond = 4'(cd);
            #1;
            check($sformatf("cond_true icc=%0h cond=%0h", f, cd), 32'(cond_true),
                  32'(bicc(4'(cd), 4'(f))));
         end
      end

      // reset mid-trap: from CWP=0 the save target 7 is invalid
      cyc(4'b0000, 0, 0, 0, 1, 8'h80);
      cyc(4'b0000, 0, 1, 0, 0, 8'h00);
      #1 clr = 1'b0;
      #1;
      check("midrst_trap", 32'(trap), 0);
      check("midrst_trap_type", 32'(trap_type), 0);
      check("midrst_wim", 32'(wim), 0);
      check("midrst_psr", 32'(psr_out), 0);
      @(negedge clk) clr = 1'b1;
      model_reset();
      cyc(4'b1001, 1, 1, 0, 0, 8'h00, 1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/psr_window_unit.md
# psr_window_unit

Parametrised successor to the Program Status Register in the SPARC8 datapath. It holds the integer condition codes (icc), a current window pointer (CWP) with SAVE/RESTORE wrap-around, and a window invalid mask (WIM). It detects window overflow and underflow traps, and evaluates the 4-bit Bicc branch condition against the registered icc. It sits between the ALU flag outputs and the control unit / branch logic.

## Interface
- NWINDOWS, 8: number of register windows, legal range 2..32.
- CWP_W, derived as max(1, clog2(NWINDOWS)): width of CWP. Not overridable.
- Clk  in  1  rising-edge clock.
- Clr  in  1  asynchronous, active-low reset.
- Z, N, C, V  in  1 each  ALU flags for this cycle.
- LE  in  1  load enable for icc.
- Save  in  1  window SAVE request, one cycle per operation.
- Restore  in  1  window RESTORE request, one cycle per operation.
- WIM_LE  in  1  load enable for WIM.
- WIM_In  in  NWINDOWS  new WIM value.
- Cond  in  4  Bicc condition field.
- PSR_Out  out  4  registered icc, as {Z,N,C,V}.
- bit_C  out  1  registered carry; always equals PSR_Out[1].
- CWP  out  CWP_W  current window pointer.
- WIM  out  NWINDOWS  registered window invalid mask.
- Cond_True  out  1  combinational result of Cond evaluated on PSR_Out.
- Trap  out  1  one-cycle registered trap pulse.
- Trap_Type  out  2  01 = overflow, 10 = underflow, 00 = none. Valid while Trap=1, otherwise 00.

## Operation
- **Reset.** While Clr=0, asynchronously force PSR_Out=0, bit_C=0, CWP=0, WIM=0, Trap=0 and Trap_Type=00.
- **icc update.** When LE=1, at the clock edge set PSR_Out<={Z,N,C,V} and bit_C<=C. When LE=0, hold.
- **SAVE.** The target is (CWP-1) mod NWINDOWS, so CWP=0 wraps to NWINDOWS-1.
  - If WIM[target]=1: CWP holds, and on the next cycle Trap=1 with Trap_Type=01.
  - Otherwise: CWP<=target.
- **RESTORE.** The target is (CWP+1) mod NWINDOWS, so CWP=NWINDOWS-1 wraps to 0.
  - If WIM[target]=1: CWP holds, and Trap=1 with Trap_Type=10.
  - Otherwise: CWP<=target.
- **Save and Restore in the same cycle.** Treated as a NOP: CWP holds and no trap is raised.
- **WIM update.** When WIM_LE=1, WIM<=WIM_In. A SAVE or RESTORE in the same cycle checks against the old WIM.
- **Independence.** LE, window operations and WIM_LE act independently in the same cycle, and all take effect.
- **Traps.** Trap is a single-cycle pulse per offending request. Back-to-back offending requests produce back-to-back pulses. A non-trapping cycle returns Trap to 0.
- **Bicc decode.** Cond_True is computed from the registered flags:
  - 0 never, 1 Z, 2 Z|(N^V), 3 N^V.
  - 4 C|Z, 5 C, 6 N, 7 V.
  - 8 always, 9 !Z, A !(Z|(N^V)), B !(N^V).
  - C !(C|Z), D !C, E !N, F !V.
- **Non-power-of-two NWINDOWS.** CWP never takes a value of NWINDOWS or above.

## Timing
- All state updates occur on the rising Clk edge. Reset is the only asynchronous path.
- icc latency: 1 cycle from LE to PSR_Out. Cond_True reflects new flags in the same cycle PSR_Out changes, with no internal bypass.
- CWP latency: 1 cycle from Save/Restore to CWP.
- Trap latency: Trap and Trap_Type assert in the cycle after the request edge, for exactly 1 cycle.
- Reset mid-operation: Clr falling clears all outputs immediately, including a Trap pulse in progress. On the first rising edge after Clr returns high, inputs are sampled normally.

## Test plan
- **Reset and icc load.** Hold Clr=0, then release. Present Z=1, N=0, C=1, V=1 with LE=1.
  - During reset: all outputs 0.
  - After one edge: PSR_Out=1011, bit_C=1. With LE=0 and new flags, PSR_Out holds.
- **SAVE wrap.** NWINDOWS=8, WIM=0, CWP=0, pulse Save. Then CWP=7 and RESTORE.
  - SAVE gives CWP=7, no trap. RESTORE gives CWP=0.
- **Overflow and underflow traps.** Load WIM=8'b1000_0000 at CWP=0, then Save.
  - SAVE: CWP stays 0; Trap=1 for one cycle with Trap_Type=01.
  - Then load WIM=8'b0000_0010 and Restore: CWP stays 0; Trap=1 with Trap_Type=10.
- **Same-cycle collisions.**
  - Save=Restore=1: CWP unchanged, Trap=0.
  - Save with WIM_LE setting the target bit in the same cycle: SAVE succeeds against the old WIM.
- **Bicc sweep.** Load each of the 16 icc values and sweep Cond from 0 to F. Cond_True matches the decode list in Operation, e.g. icc=0100 with Cond=3 gives 1, and with Cond=B gives 0.
- **NWINDOWS=5 and asynchronous reset mid-trap.**
  - Restore from CWP=4 gives 0; Save from 0 gives 4.
  - Assert Clr=0 during a Trap pulse: Trap drops immediately.
